wam_game_controller: RTL
========================

# wam_game_controller

Sequencing controller for the whack-a-mole game. Owns the game state machine (idle, play, pause, over), the countdown second counter, mole placement and lifetime, hit/miss scoring, and LED drive. Sits between the divided-clock tick sources and buttons/switches on one side, and the seven-segment display decoders (score, time left) on the other.

## Interface

Parameters:
- `GAME_SECONDS`, 20: countdown start value, 1..31.
- `MOLE_TICKS`, 4: `mole_tick` pulses a mole stays lit before it escapes, 1..15.
- `SCORE_MAX`, 99: score and miss saturation value, at most 127.
- `LFSR_SEED`, 8'hA5: LFSR reset value, non-zero.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: **synchronous, active-low** reset.
- `sec_tick`, in, 1: one-cycle pulse, 1 Hz.
- `mole_tick`, in, 1: one-cycle pulse, mole-lifetime base.
- `btn_start`, in, 1: start/restart button level, 1 = pressed, already debounced.
- `btn_pause`, in, 1: pause button level, 1 = pressed, already debounced.
- `sw`, in, 10: slide switches, synchronous to `clock`.
- `led`, out, 10: one-hot mole LED, or all zero.
- `score`, out, 7: hits.
- `misses`, out, 7: escaped moles.
- `time_left`, out, 5: seconds remaining.
- `state`, out, 2: 00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER.
- `game_over`, out, 1: high in OVER.

## Operation

- **Button presses**: each button is edge-detected internally. A press is a rising edge, 0 then 1 on consecutive cycles.
- **Switch toggles**: `sw_q` is `sw` delayed one cycle. `toggle = sw ^ sw_q`. A hit is `toggle[mole_idx]` in PLAY.
- **LFSR**: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every cycle in every state.
- **Relocation**: candidate = `lfsr % 10`. If the candidate equals the current `mole_idx`, use `(candidate+1) % 10`. The mole never stays in the same place.
- **IDLE**:
  - `led=0`, `score=0`, `misses=0`, `time_left=GAME_SECONDS`.
  - Start press: go to PLAY, relocate mole, `age=0`.
- **PLAY**:
  - `led = 1 << mole_idx`.
  - `sec_tick` decrements `time_left`. When `sec_tick` arrives with `time_left==1`, `time_left` becomes 0 and the state goes to OVER.
  - `mole_tick` increments `age`. When `age==MOLE_TICKS-1` and `mole_tick` arrives, increment `misses` (saturating), relocate, set `age=0`.
  - On a hit: increment `score` (saturating at `SCORE_MAX`), relocate, set `age=0`.
  - Toggles on non-mole switches are ignored, unless `WAM_PENALTY_EN` is defined.
- **PAUSE**:
  - Entered by a pause press in PLAY.
  - `led=0`. `time_left`, `age`, `score`, `misses` and `mole_idx` are frozen.
  - `sw_q` keeps tracking, so toggles made during pause never register as hits on resume.
  - A pause press returns to PLAY.
- **OVER**:
  - `led=0`, `game_over=1`. Score, misses and `time_left=0` are held.
- **Restart**: a start press in PLAY, PAUSE or OVER restarts the game. It clears score, misses and age, loads `GAME_SECONDS`, relocates the mole and enters PLAY.
- **Simultaneous events**:
  - Start and pause in the same cycle: start wins.
  - Hit and escape in the same cycle: hit wins, `misses` unchanged.
  - Hit and the final `sec_tick` in the same cycle: hit is counted and the state goes to OVER.
  - Pause press and a tick in the same cycle: the tick is applied first, then the state goes to PAUSE.
- **Reset**: `reset=0` at any point forces IDLE on the next edge, regardless of state or in-flight events.

## Timing

- All outputs are registered.
- Reset values:
  - `state=00`, `led=0`, `score=0`, `misses=0`, `time_left=GAME_SECONDS`, `game_over=0`.
  - `lfsr=LFSR_SEED`, `mole_idx=0`, `age=0`.
  - `sw_q` is loaded with `sw` during reset.
- Latency:
  - Button press to new `state`: 1 cycle after the edge cycle.
  - Switch toggle to `score` increment and new `led`: 1 cycle.
  - `sec_tick` to `time_left` update: 1 cycle.
- Ticks are sampled only in PLAY. Ticks in other states are dropped, not queued.
- Saturating counters never wrap. `time_left` never goes below 0.

## Configuration

- `WAM_PENALTY_EN` defined: in PLAY, a toggle on any non-mole switch decrements `score` by 1 per cycle, saturating at 0. If the same cycle also contains a hit, only the hit applies. The mole is not relocated.
- `WAM_PENALTY_EN` not defined: non-mole toggles have no effect. The penalty logic is absent.

## Test plan

- **Reset and start**: reset low for 2 cycles, then start press.
  - Expected: `state=01`, `time_left=20`, `led` one-hot, `score=0`.
- **Hit**: with mole at index k, toggle `sw[k]`.
  - Expected: `score=1` one cycle later, `led` moves to an index ≠ k.
  - Repeat 100 times: `score` saturates at 99.
- **Escape**: no switch activity for 4 `mole_tick` pulses.
  - Expected: `misses=1` and a new mole index.
  - A hit coincident with the 4th tick gives `score+1`, `misses` unchanged.
- **Countdown**: 20 `sec_tick` pulses in PLAY.
  - Expected: `time_left=0`, `state=11`, `game_over=1`, `led=0`.
  - Then a start press gives `state=01`, `time_left=20`, `score=0`.
- **Pause**:
  - Pause press: `led=0`, `time_left` frozen across 5 `sec_tick` pulses.
  - Toggle `sw[mole]` while paused: `score` unchanged after resume.
  - Second pause press resumes with the same `mole_idx`.
- **Penalty**: with `WAM_PENALTY_EN` defined and `score=3`, toggle a wrong switch.
  - Expected: `score=2`.
  - Without the macro: `score=3`.

Source files
------------

// File: rtl/wam_game_controller.sv
// wam_game_controller: whack-a-mole sequencing controller.
// Owns the game FSM (idle/play/pause/over), countdown, mole placement and
// lifetime, hit/miss scoring and LED drive. All outputs are registered.
// Optional feature macro: WAM_PENALTY_EN (non-mole toggles cost one point).
module wam_game_controller #(
  parameter int         GAME_SECONDS = 20,
  parameter int         MOLE_TICKS   = 4,
  parameter int         SCORE_MAX    = 99,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       mole_tick,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [9:0] sw,
  output logic [9:0] led,
  output logic [6:0] score,
  output logic [6:0] misses,
  output logic [4:0] time_left,
  output logic [1:0] state,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  localparam logic [6:0] SCORE_SAT = 7'(SCORE_MAX);
  localparam logic [4:0] TIME_INIT = 5'(GAME_SECONDS);
  localparam logic [3:0] AGE_LAST  = 4'(MOLE_TICKS - 1);

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_next;
  logic [3:0] mole_q, mole_d;
  logic [3:0] age_q, age_d;
  logic [6:0] score_d, misses_d;
  logic [4:0] time_d;
  logic [9:0] sw_q, led_d, toggle, mole_mask;
  logic       start_q, pause_q;
  logic       start_press, pause_press, hit, escape, last_sec;
  logic [3:0] cand, reloc_idx;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Next mole position: never the current one, so a hit always visibly moves it
  assign cand      = 4'(lfsr_q % 8'd10);
  assign reloc_idx = (cand != mole_q) ? cand : ((cand == 4'd9) ? 4'd0 : cand + 4'd1);

  assign start_press = btn_start & ~start_q;
  assign pause_press = btn_pause & ~pause_q;
  assign toggle      = sw ^ sw_q;
  assign mole_mask   = 10'd1 << mole_q;
  assign hit         = |(toggle & mole_mask);
  assign escape      = mole_tick && (age_q == AGE_LAST);
  assign last_sec    = sec_tick && (time_left == 5'd1);
  assign state       = state_q;

  // Next-state and datapath decisions; start always wins and restarts the game
  always_comb begin
    state_d  = state_q;
    mole_d   = mole_q;
    age_d    = age_q;
    score_d  = score;
    misses_d = misses;
    time_d   = time_left;
    if (start_press) begin
      state_d  = S_PLAY;
      score_d  = '0;
      misses_d = '0;
      age_d    = '0;
      time_d   = TIME_INIT;
      mole_d   = reloc_idx;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          score_d  = '0;
          misses_d = '0;
          age_d    = '0;
          time_d   = TIME_INIT;
        end
        S_PLAY: begin
          if (sec_tick && (time_left != 5'd0)) time_d = time_left - 5'd1;
          if (hit) begin
            score_d = (score < SCORE_SAT) ? score + 7'd1 : score;
            mole_d  = reloc_idx;
            age_d   = '0;
          end else if (escape) begin
            misses_d = (misses < SCORE_SAT) ? misses + 7'd1 : misses;
            mole_d   = reloc_idx;
            age_d    = '0;
          end else if (mole_tick) begin
            age_d = age_q + 4'd1;
          end
`ifdef WAM_PENALTY_EN
          if (!hit && (|(toggle & ~mole_mask)) && (score != 7'd0)) score_d = score - 7'd1;
`endif
          if (last_sec) state_d = S_OVER;
          else if (pause_press) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (pause_press) state_d = S_PLAY;
        end
        S_OVER: begin
          time_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
    led_d = (state_d == S_PLAY) ? (10'd1 << mole_d) : '0;
  end

  // State and output registers; synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      led       <= '0;
      score     <= '0;
      misses    <= '0;
      time_left <= TIME_INIT;
      game_over <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      mole_q    <= '0;
      age_q     <= '0;
      sw_q      <= sw;
      start_q   <= btn_start;
      pause_q   <= btn_pause;
    end else begin
      state_q   <= state_d;
      led       <= led_d;
      score     <= score_d;
      misses    <= misses_d;
      time_left <= time_d;
      game_over <= (state_d == S_OVER);
      lfsr_q    <= lfsr_next;
      mole_q    <= mole_d;
      age_q     <= age_d;
      sw_q      <= sw;
      start_q   <= btn_start;
      pause_q   <= btn_pause;
    end
  end

endmodule
